temporizador_nivel2: RTL and testbench
======================================

// Module: temporizador_nivel2
// PURPOSE
//  Consumer end of the time-entry interface: receives BCD key digits (D) with
//  their active-low strobe (loadn) and the time base (pgt_1Hz). It assembles a
//  4-digit MM:SS preset, counts it down while cooking (enablen=0), and drives
//  display digits plus zero/done status to the microwave controller.
// PARAMETERS
//  SYNC_STAGES  2  flops in each input synchronizer (loadn, pgt_1Hz); legal range >=2
// PORTS
//  clk        in   1  system clock
//  reset      in   1  asynchronous, active-high; clears all state
//  clear      in   1  synchronous clear of the preset digits; honoured in LOAD only
//  enablen    in   1  0 = cook/count, 1 = stop/allow digit entry
//  D          in   4  BCD key digit from the time-entry block
//  loadn      in   1  active-low key strobe; low while a key is held
//  pgt_1Hz    in   1  time base; a rising edge = one tick
//  sec_ones   out  4  BCD seconds units
//  sec_tens   out  4  BCD seconds tens
//  min_ones   out  4  BCD minutes units
//  min_tens   out  4  BCD minutes tens
//  zero       out  1  1 when all four digits are 0
//  done       out  1  single-cycle pulse when the countdown reaches 00:00
// BEHAVIOUR
//  - reset: all digits = 0, zero = 1, done = 0, FSM = LOAD, synchronizers = 1/0 (idle levels).
//  - loadn and pgt_1Hz each pass through SYNC_STAGES flops. The output of the last flop is compared with a
//    one-cycle-delayed copy to detect edges.
//  - key_evt = falling edge of synced loadn. It fires once per key press, however long the key is held.
//    It happens SYNC_STAGES+1 clk edges after loadn falls.
//  - tick = rising edge of synced pgt_1Hz. It is a 1-cycle event with the same latency.
//  - FSM states LOAD, COUNT, DONE:
//    LOAD : on key_evt with D<=9, shift left in one cycle:
//           min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=D.
//           D>9 is ignored. clear=1 zeroes all digits and takes priority over key_evt in the same cycle.
//           Go to COUNT when enablen=0 and zero=0. If enablen=0 and zero=1, stay in LOAD.
//    COUNT: on tick, decrement MM:SS by one second:
//           sec_ones 0->9 with borrow; sec_tens 0->5 with borrow;
//           min_ones 0->9 with borrow; min_tens decrements.
//           Entered seconds tens >5 (e.g. 0:90) simply count down and are not normalised.
//           key_evt and clear are ignored.
//           enablen=1 -> LOAD and hold the remaining time (pause). New digits then shift into the remaining time.
//           When a tick brings the value to 00:00 -> DONE, and done=1 for exactly that next cycle.
//    DONE : digits stay 0 and tick is ignored. When enablen=1 -> LOAD.
//  - zero is combinational from the digit registers; done is registered.
//  - If tick and enablen rising occur in the same cycle in COUNT, the tick is applied first, then the move to LOAD.
//  - Decrement is never applied at 00:00, so there is no wrap to 99:59.
//  - reset mid-count: immediate return to the reset values with no done pulse.
// TESTING
//  1 reset, then key presses 1,3,0 (loadn low for 50 clk each, enablen=1) -> digits 01:30, zero=0.
//  2 hold loadn low for 1000 clk with D=7 -> exactly one shift; D=4'hC strobe -> digits unchanged.
//  3 preset 00:02, enablen=0, two pgt_1Hz edges -> 00:01 then 00:00; done=1 for 1 clk; state DONE.
//  4 preset 10:00, enablen=0, 1 tick -> 09:59; preset 01:00 -> 00:59; enablen=1 mid-count -> value frozen.
//  5 clear=1 with a simultaneous key_evt in LOAD -> 00:00; enablen=0 at 00:00 -> no count, no done.
//  6 assert reset during COUNT at 05:17 -> all digits 0, zero=1, done=0 on the same edge (async).

Source files
------------

// File: rtl/temporizador_nivel2.sv
// rtl/temporizador_nivel2.sv - MM:SS preset entry and countdown timer with synchronized key strobe and 1 Hz tick
module temporizador_nivel2 #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enablen,
    input  logic [3:0] D,
    input  logic       loadn,
    input  logic       pgt_1Hz,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       zero,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_COUNT,
        ST_DONE
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] loadn_sync;
    logic [SYNC_STAGES-1:0] pgt_sync;
    logic                   loadn_prev;
    logic                   pgt_prev;
    logic                   key_evt;
    logic                   tick;

    // Synchronizers reset to the idle levels so no spurious edge follows reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loadn_sync <= '1;
            pgt_sync   <= '0;
            loadn_prev <= 1'b1;
            pgt_prev   <= 1'b0;
        end else begin
            loadn_sync <= {loadn_sync[SYNC_STAGES-2:0], loadn};
            pgt_sync   <= {pgt_sync[SYNC_STAGES-2:0], pgt_1Hz};
            loadn_prev <= loadn_sync[SYNC_STAGES-1];
            pgt_prev   <= pgt_sync[SYNC_STAGES-1];
        end
    end

    assign key_evt = loadn_prev & ~loadn_sync[SYNC_STAGES-1];
    assign tick    = ~pgt_prev & pgt_sync[SYNC_STAGES-1];

    assign zero = (sec_ones == 4'd0) && (sec_tens == 4'd0) &&
                  (min_ones == 4'd0) && (min_tens == 4'd0);

    logic [3:0] dec_sec_ones;
    logic [3:0] dec_sec_tens;
    logic [3:0] dec_min_ones;
    logic [3:0] dec_min_tens;
    logic       last_second;

    always_comb begin
        dec_sec_ones = sec_ones;
        dec_sec_tens = sec_tens;
        dec_min_ones = min_ones;
        dec_min_tens = min_tens;
        if (sec_ones != 4'd0) begin
            dec_sec_ones = sec_ones - 4'd1;
        end else begin
            dec_sec_ones = 4'd9;
            if (sec_tens != 4'd0) begin
                dec_sec_tens = sec_tens - 4'd1;
            end else begin
                dec_sec_tens = 4'd5;
                if (min_ones != 4'd0) begin
                    dec_min_ones = min_ones - 4'd1;
                end else begin
                    dec_min_ones = 4'd9;
                    dec_min_tens = min_tens - 4'd1;
                end
            end
        end
    end

    assign last_second = (sec_ones == 4'd1) && (sec_tens == 4'd0) &&
                         (min_ones == 4'd0) && (min_tens == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_LOAD;
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (clear) begin
                        sec_ones <= 4'd0;
                        sec_tens <= 4'd0;
                        min_ones <= 4'd0;
                        min_tens <= 4'd0;
                    end else if (key_evt && (D <= 4'd9)) begin
                        min_tens <= min_ones;
                        min_ones <= sec_tens;
                        sec_tens <= sec_ones;
                        sec_ones <= D;
                    end
                    if (!enablen && !zero) begin
                        state <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    // A tick in the same cycle as a pause still lands before the pause
                    if (tick && !zero) begin
                        sec_ones <= dec_sec_ones;
                        sec_tens <= dec_sec_tens;
                        min_ones <= dec_min_ones;
                        min_tens <= dec_min_tens;
                    end
                    if (tick && last_second) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (enablen) begin
                        state <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    if (enablen) begin
                        state <= ST_LOAD;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_temporizador_nivel2.sv
// tb/tb_temporizador_nivel2.sv - scoreboard bench for temporizador_nivel2
module tb_temporizador_nivel2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       enablen = 1'b1;
    logic [3:0] D = 4'd0;
    logic       loadn = 1'b1;
    logic       pgt_1Hz = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       zero, done;

    temporizador_nivel2 #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .clear(clear), .enablen(enablen),
        .D(D), .loadn(loadn), .pgt_1Hz(pgt_1Hz),
        .sec_ones(sec_ones), .sec_tens(sec_tens),
        .min_ones(min_ones), .min_tens(min_tens),
        .zero(zero), .done(done)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string name, input logic [15:0] digits, input logic z, input int dones);
        logic [15:0] act;
        @(negedge clk);
        #1;
        act = {min_tens, min_ones, sec_tens, sec_ones};
        tests++;
        if (act !== digits) begin
            fails++;
            $display("FAIL %s: digits got %h expected %h", name, act, digits);
        end
        if (zero !== z) begin
            fails++;
            $display("FAIL %s: zero got %b expected %b", name, zero, z);
        end
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL %s: done got %b expected 0", name, done);
        end
        if (done_cnt != dones) begin
            fails++;
            $display("FAIL %s: dones got %0d expected %0d", name, done_cnt, dones);
        end
    endtask

    task automatic press(input logic [3:0] d, input int hold);
        @(posedge clk); #1;
        D = d; loadn = 1'b0;
        repeat (hold) @(posedge clk);
        #1 loadn = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic preset(input logic [15:0] v);
        for (int i = 3; i >= 0; i--) press(v[i*4 +: 4], 50);
    endtask

    task automatic tick_pulse();
        @(posedge clk); #1 pgt_1Hz = 1'b1;
        repeat (5) @(posedge clk);
        #1 pgt_1Hz = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        idle(3);
        chk("reset_state", 16'h0000, 1'b1, 0);
        #1 reset = 1'b0;
        idle(3);

        press(4'd1, 50); press(4'd3, 50); press(4'd0, 50);
        chk("keys_130", 16'h0130, 1'b0, 0);

        press(4'd7, 1000);
        chk("long_hold_one_shift", 16'h1307, 1'b0, 0);
        press(4'hC, 50);
        chk("non_bcd_ignored", 16'h1307, 1'b0, 0);

        preset(16'h0002);
        chk("preset_0002", 16'h0002, 1'b0, 0);
        enablen = 1'b0;
        idle(3);
        tick_pulse();
        chk("count_0001", 16'h0001, 1'b0, 0);
        tick_pulse();
        chk("count_0000_done", 16'h0000, 1'b1, 1);
        tick_pulse();
        chk("done_ignores_tick", 16'h0000, 1'b1, 1);

        enablen = 1'b1;
        preset(16'h1000);
        enablen = 1'b0;
        idle(3);
        tick_pulse();
        chk("borrow_1000_0959", 16'h0959, 1'b0, 1);
        enablen = 1'b1;
        preset(16'h0100);
        enablen = 1'b0;
        idle(3);
        tick_pulse();
        chk("borrow_0100_0059", 16'h0059, 1'b0, 1);
        enablen = 1'b1;
        idle(2);
        tick_pulse();
        chk("pause_frozen", 16'h0059, 1'b0, 1);
        press(4'd3, 50);
        chk("pause_shift_in", 16'h0593, 1'b0, 1);
        enablen = 1'b0;
        idle(3);
        tick_pulse();
        chk("resume_0592", 16'h0592, 1'b0, 1);
        enablen = 1'b1;
        preset(16'h0090);
        enablen = 1'b0;
        idle(3);
        tick_pulse();
        chk("unnormalised_0090_0089", 16'h0089, 1'b0, 1);

        enablen = 1'b1;
        idle(2);
        @(posedge clk); #1 D = 4'd5; loadn = 1'b0;
        @(posedge clk); @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        repeat (50) @(posedge clk);
        #1 loadn = 1'b1;
        idle(10);
        chk("clear_priority", 16'h0000, 1'b1, 1);
        enablen = 1'b0;
        idle(3);
        tick_pulse();
        tick_pulse();
        chk("zero_no_count", 16'h0000, 1'b1, 1);

        enablen = 1'b1;
        preset(16'h0517);
        chk("preset_0517", 16'h0517, 1'b0, 1);
        enablen = 1'b0;
        idle(3);
        @(posedge clk); #1 reset = 1'b1;
        chk("async_reset_mid_count", 16'h0000, 1'b1, 1);
        #1 reset = 1'b0;
        idle(3);
        tick_pulse();
        chk("after_reset_idle", 16'h0000, 1'b1, 1);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
